// File: rtl/wavegen_pkg.sv
// Shared definitions for the wave generator: shape codes, FSM encodings,
// default sample width and the flat-wave predicate.
package wavegen_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int FULL_SCALE = (1 << DATA_W_DEF) - 1;

  typedef enum logic [1:0] {
    SHAPE_TRI = 2'd0,
    SHAPE_SAW = 2'd1,
    SHAPE_SQR = 2'd2,
    SHAPE_DC  = 2'd3
  } shape_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_DC   = 2'd3
  } state_e;

  // A wave with no excursion or no motion is just its mean level.
  function automatic logic dc_cond(shape_e shape, logic amp_zero, logic step_zero, logic flat);
    return amp_zero | step_zero | flat | (shape == SHAPE_DC);
  endfunction

endpackage

// File: rtl/wavegen_tick.sv
// Sample-rate divider: one tick every div+1 enabled cycles; en=0 or clr
// restarts the count.
module wavegen_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == div);
    cnt_d = (!en || clr || tick) ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wavegen_amp.sv
// Test-signal source: triangle/saw/square/DC wave between clamped
// lo=mean-amp and hi=mean+amp, config applied only at period boundaries.
module wavegen_amp
  import wavegen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STEP_W = 12,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] cfg_amp,
  input  logic [DATA_W-1:0] cfg_mean,
  input  logic [1:0]        cfg_shape,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [DATA_W-1:0] data_out,
  output logic              sample_stb,
  output logic              period_done,
  output logic              clipped
);

  localparam int SUM_W = ((DATA_W > STEP_W) ? DATA_W : STEP_W) + 1;

  logic [DATA_W-1:0] sh_amp_q, sh_amp_d, sh_mean_q, sh_mean_d;
  shape_e            sh_shape_q, sh_shape_d;
  logic [STEP_W-1:0] sh_step_q, sh_step_d;
  logic [DIV_W-1:0]  sh_div_q, sh_div_d;

  logic [DATA_W-1:0] ac_amp_q, ac_amp_d, ac_mean_q, ac_mean_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  shape_e            ac_shape_q, ac_shape_d;
  logic [STEP_W-1:0] ac_step_q, ac_step_d;
  logic [DIV_W-1:0]  ac_div_q, ac_div_d;
  logic              clip_q, clip_d;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, dout_q, dout_d;
  logic              stb_q, stb_d, pd_q, pd_d;

  logic              tick, saw_wrap, rise_hit, fall_hit, boundary, apply, div_clr;
  logic [DATA_W:0]   lo_raw, hi_raw;
  logic [DATA_W-1:0] n_lo, n_hi;
  logic              n_clip;
  logic [SUM_W-1:0]  acc_up;
  logic [DATA_W-1:0] e_amp, e_mean, e_lo, e_hi;
  shape_e            e_shape;
  logic [STEP_W-1:0] e_step;
  logic [DIV_W-1:0]  e_div;
  logic              e_dc;

  wavegen_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (div_clr),
    .div  (ac_div_q),
    .tick (tick)
  );

  // Shadow follows cfg_load combinationally so a load coinciding with a
  // boundary is the one that gets applied there.
  always_comb begin
    sh_amp_d   = sh_amp_q;
    sh_mean_d  = sh_mean_q;
    sh_shape_d = sh_shape_q;
    sh_step_d  = sh_step_q;
    sh_div_d   = sh_div_q;
    if (cfg_load) begin
      sh_amp_d   = cfg_amp;
      sh_mean_d  = cfg_mean;
      sh_shape_d = shape_e'(cfg_shape);
      sh_step_d  = cfg_step;
      sh_div_d   = cfg_div;
    end
  end

  // Both operands are below 2^DATA_W, so the extra MSB is the sign of
  // mean-amp and the carry of mean+amp.
  always_comb begin
    lo_raw = {1'b0, sh_mean_d} - {1'b0, sh_amp_d};
    hi_raw = {1'b0, sh_mean_d} + {1'b0, sh_amp_d};
    n_lo   = lo_raw[DATA_W] ? '0 : lo_raw[DATA_W-1:0];
    n_hi   = hi_raw[DATA_W] ? '1 : hi_raw[DATA_W-1:0];
    n_clip = lo_raw[DATA_W] | hi_raw[DATA_W];
  end

  always_comb begin
    acc_up   = SUM_W'(acc_q) + SUM_W'(ac_step_q);
    rise_hit = acc_up >= SUM_W'(hi_q);
    fall_hit = SUM_W'(acc_q) <= SUM_W'(lo_q) + SUM_W'(ac_step_q);
    saw_wrap = (state_q == ST_RISE) && (ac_shape_q == SHAPE_SAW) && (acc_q == hi_q);
    boundary = tick && (saw_wrap || ((state_q == ST_FALL) && fall_hit));
    apply    = boundary || (state_q == ST_IDLE) || (state_q == ST_DC);
    e_amp    = apply ? sh_amp_d   : ac_amp_q;
    e_mean   = apply ? sh_mean_d  : ac_mean_q;
    e_shape  = apply ? sh_shape_d : ac_shape_q;
    e_step   = apply ? sh_step_d  : ac_step_q;
    e_div    = apply ? sh_div_d   : ac_div_q;
    e_lo     = apply ? n_lo       : lo_q;
    e_hi     = apply ? n_hi       : hi_q;
    e_dc     = dc_cond(e_shape, e_amp == '0, e_step == '0, e_lo == e_hi);
    div_clr  = apply && (e_div != ac_div_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tick) state_d = e_dc ? ST_DC : ST_RISE;
      ST_RISE: if (tick) begin
        if (saw_wrap)                                state_d = e_dc ? ST_DC : ST_RISE;
        else if (rise_hit && ac_shape_q != SHAPE_SAW) state_d = ST_FALL;
      end
      ST_FALL: if (boundary) state_d = e_dc ? ST_DC : ST_RISE;
      ST_DC:   if (!e_dc)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ac_amp_d   = e_amp;
    ac_mean_d  = e_mean;
    ac_shape_d = e_shape;
    ac_step_d  = e_step;
    ac_div_d   = e_div;
    lo_d       = e_lo;
    hi_d       = e_hi;
    clip_d     = apply ? n_clip : clip_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    pd_d       = 1'b0;
    stb_d      = tick;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: acc_d = e_lo;
        ST_RISE: begin
          if (saw_wrap) begin
            acc_d = e_lo;
            pd_d  = 1'b1;
          end else if (rise_hit) acc_d = hi_q;
          else                   acc_d = acc_up[DATA_W-1:0];
        end
        ST_FALL: begin
          if (fall_hit) begin
            acc_d = e_lo;
            pd_d  = 1'b1;
          end else acc_d = acc_q - DATA_W'(ac_step_q);
        end
        default: ;
      endcase
      // Square output only looks at which half the ramp is in.
      unique case (state_d)
        ST_RISE: dout_d = (e_shape == SHAPE_SQR) ? e_hi : acc_d;
        ST_FALL: dout_d = (e_shape == SHAPE_SQR) ? e_lo : acc_d;
        ST_DC:   dout_d = e_mean;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_amp_q   <= '0;
      sh_mean_q  <= '0;
      sh_shape_q <= SHAPE_TRI;
      sh_step_q  <= STEP_W'(1);
      sh_div_q   <= '0;
      ac_amp_q   <= '0;
      ac_mean_q  <= '0;
      ac_shape_q <= SHAPE_TRI;
      ac_step_q  <= STEP_W'(1);
      ac_div_q   <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      clip_q     <= 1'b0;
      acc_q      <= '0;
      dout_q     <= '0;
      stb_q      <= 1'b0;
      pd_q       <= 1'b0;
    end else begin
      sh_amp_q   <= sh_amp_d;
      sh_mean_q  <= sh_mean_d;
      sh_shape_q <= sh_shape_d;
      sh_step_q  <= sh_step_d;
      sh_div_q   <= sh_div_d;
      ac_amp_q   <= ac_amp_d;
      ac_mean_q  <= ac_mean_d;
      ac_shape_q <= ac_shape_d;
      ac_step_q  <= ac_step_d;
      ac_div_q   <= ac_div_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      clip_q     <= clip_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      stb_q      <= stb_d;
      pd_q       <= pd_d;
    end
  end

  assign data_out    = dout_q;
  assign sample_stb  = stb_q;
  assign period_done = pd_q;
  assign clipped     = clip_q;

endmodule
